// File: rtl/led_ctrl_pkg.sv
// Shared types and widths for the shared LED bank arbiter.
// Imported by the round-robin picker and the arbiter top.
package led_ctrl_pkg;

    localparam int NREQ    = 4;
    localparam int LED_W   = 8;
    localparam int IDX_W   = 2;
    localparam int DWELL_W = 16;
    localparam int BLANK_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        SHOW,
        BLANK
    } state_t;

    function automatic logic [LED_W-1:0] slice(
        input logic [NREQ*LED_W-1:0] d,
        input logic [IDX_W-1:0]      i
    );
        return d[i*LED_W +: LED_W];
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first requester at or after
// last_grant+1, wrapping, so the previous owner is considered last.
module rr_pick
    import led_ctrl_pkg::*;
(
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] last_grant,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        valid = |req;
        idx   = last_grant;
        cand  = '0;
        // walk farthest-to-nearest so the nearest set request wins
        for (int k = NREQ; k >= 1; k--) begin
            cand = last_grant + IDX_W'(k);
            if (req[cand]) begin
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/led_share_arb.sv
// Shares one 8-bit LED bank among four requesters: round-robin grant,
// fixed dwell with early release, optional dark gap between owners.
module led_share_arb
    import led_ctrl_pkg::*;
#(
    parameter int unsigned DWELL_CYCLES = 1000,
    parameter int unsigned BLANK_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*LED_W-1:0] req_data,
    output logic [NREQ-1:0]       grant,
    output logic [LED_W-1:0]      led,
    output logic                  busy
);

    localparam logic [DWELL_W-1:0] DWELL_LD = DWELL_W'(DWELL_CYCLES - 1);
    localparam logic [BLANK_W-1:0] BLANK_LD =
        (BLANK_CYCLES > 0) ? BLANK_W'(BLANK_CYCLES - 1) : '0;

    state_t             state, state_n;
    logic [NREQ-1:0]    grant_n;
    logic [LED_W-1:0]   led_n;
    logic               busy_n;
    logic [DWELL_W-1:0] dwell, dwell_n;
    logic [BLANK_W-1:0] blank, blank_n;
    logic [IDX_W-1:0]   last, last_n;
    logic               pick_valid;
    logic [IDX_W-1:0]   pick_idx;

    rr_pick u_pick (
        .req        (req),
        .last_grant (last),
        .valid      (pick_valid),
        .idx        (pick_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            grant <= '0;
            led   <= '0;
            busy  <= 1'b0;
            dwell <= '0;
            blank <= '0;
            last  <= IDX_W'(NREQ - 1);
        end else begin
            state <= state_n;
            grant <= grant_n;
            led   <= led_n;
            busy  <= busy_n;
            dwell <= dwell_n;
            blank <= blank_n;
            last  <= last_n;
        end
    end

    // last doubles as the current owner index while in SHOW
    always_comb begin
        state_n = state;
        grant_n = '0;
        led_n   = '0;
        dwell_n = dwell;
        blank_n = blank;
        last_n  = last;
        unique case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_n           = SHOW;
                    grant_n[pick_idx] = 1'b1;
                    led_n             = slice(req_data, pick_idx);
                    dwell_n           = DWELL_LD;
                    last_n            = pick_idx;
                end
            end
            SHOW: begin
                if (!req[last] || dwell == '0) begin
                    dwell_n = '0;
                    if (BLANK_CYCLES > 0) begin
                        state_n = BLANK;
                        blank_n = BLANK_LD;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    grant_n[last] = 1'b1;
                    led_n         = slice(req_data, last);
                    dwell_n       = dwell - 1'b1;
                end
            end
            BLANK: begin
                if (blank == '0) begin
                    state_n = IDLE;
                end else begin
                    blank_n = blank - 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        busy_n = (state_n != IDLE);
    end

endmodule
